// File: rtl/fcvt_s_w_pipe.sv
// fcvt_s_w_pipe: 3-stage int32/uint32 -> binary32 converter, RNE.
// Valid/ready on both sides; all stages advance together.
module fcvt_s_w_pipe #(
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic        uns,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        nx,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef struct packed {
    logic        s;
    logic        z;
    logic [31:0] mag;
  } s1_t;

  typedef struct packed {
    logic        s;
    logic        z;
    logic [30:0] m;
    logic [7:0]  e;
  } s2_t;

  function automatic logic [4:0] clz(input logic [31:0] v);
    clz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) clz = 5'(31 - i);
    end
  endfunction

  logic        v1, v2, v3;
  s1_t         r1, n1;
  s2_t         r2, n2;
  logic [31:0] y3, y_n;
  logic        nx3, nx_n;
  logic        advance;
  logic [4:0]  lz;
  logic [22:0] frac;
  logic        g, st, up;
  logic [30:0] ef;

  assign advance  = ~v3 | out_ready;
  assign in_ready = advance;

  // Stage 1 next: sign and magnitude of the operand.
  always_comb begin
    n1     = '0;
    n1.s   = ~uns & x1[31];
    n1.mag = n1.s ? (~x1 + 32'd1) : x1;
    n1.z   = (x1 == 32'd0);
  end

  // Stage 2 next: normalize so the leading one sits at bit 31.
  always_comb begin
    n2   = '0;
    lz   = clz(r1.mag);
    n2.s = r1.s;
    n2.z = r1.z;
    n2.m = 31'(r1.mag << lz);
    n2.e = 8'd158 - {3'd0, lz};
  end

  // Stage 3 next: round to nearest even; carry ripples into exponent.
  always_comb begin
    frac = r2.m[30:8];
    g    = r2.m[7];
    st   = |r2.m[6:0];
    up   = g & (st | frac[0]);
    ef   = {r2.e, frac} + {30'd0, up};
    y_n  = r2.z ? 32'd0 : {r2.s, ef};
    nx_n = ~r2.z & (g | st);
  end

  // Stage 1 register: capture operand when accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) r1 <= n1;
    end
  end

  // Stage 2 register: normalized mantissa and biased exponent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2 <= 1'b0;
      r2 <= '0;
    end else if (advance) begin
      v2 <= v1;
      r2 <= n2;
    end
  end

  // Stage 3 register: packed result and inexact flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3  <= 1'b0;
      y3  <= 32'd0;
      nx3 <= 1'b0;
    end else if (advance) begin
      v3  <= v2;
      y3  <= y_n;
      nx3 <= nx_n;
    end
  end

  assign out_valid = v3;
  assign y  = (ZERO_ON_IDLE && !v3) ? 32'd0 : y3;
  assign nx = (ZERO_ON_IDLE && !v3) ? 1'b0 : nx3;

endmodule

// File: doc/fcvt_s_w_pipe.md
Name: fcvt_s_w_pipe

Overview:
- Pipelined integer-to-single-precision converter (fcvt.s.w / fcvt.s.wu) for the FPU.
- It is the producer side of the float compare path: it creates IEEE-754 single values that the compare units consume.
- Three-stage pipeline with a valid/ready handshake on both sides, using round-to-nearest-even.
- It never emits subnormals or -0, so downstream zero detection by exponent stays exact.

Parameters:
- ZERO_ON_IDLE, default 1: when 1, y and nx read 0 whenever out_valid=0; when 0, they hold their last stage-3 value.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- x1  in  32  integer operand.
- uns  in  1  1 = treat x1 as unsigned (fcvt.s.wu), 0 = signed two's complement.
- in_valid  in  1  operand valid.
- in_ready  out  1  pipeline can accept an operand this cycle.
- y  out  32  single-precision result.
- nx  out  1  inexact flag (rounding discarded nonzero bits).
- out_valid  out  1  y/nx valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rstn=0, asynchronous): all stage valid bits clear, out_valid=0, y=0, nx=0, and all datapath registers clear. Assertion mid-operation discards all in-flight operands. in_ready is 1 as soon as rstn=1.
- Handshake:
  - advance = ~out_valid | out_ready, and in_ready = advance.
  - On each edge with advance=1, every stage shifts forward, including bubbles.
  - An operand is captured only when in_valid & in_ready.
  - When advance=0, every stage holds, and y/nx/out_valid stay stable until out_ready.
- Latency: exactly 3 cycles from acceptance to out_valid with no stalls. Throughput is 1 per cycle.
- S1 (sign/magnitude):
  - s = ~uns & x1[31].
  - mag = s ? -x1 : x1, as a 32-bit unsigned value. For signed 0x80000000 this gives mag = 0x80000000.
  - z = (x1 == 0).
- S2 (normalize):
  - lz = count of leading zeros of mag (0..31; don't-care when z).
  - m = mag << lz, so m[31] = 1.
  - e = 158 - lz (127 + 31 - lz).
- S3 (round/pack):
  - frac = m[30:8], G = m[7], St = |m[6:0].
  - Round up iff G & (St | frac[0]).
  - frac+1 overflowing 23 bits gives frac = 0 and e = e+1. Maximum e is 159, so the exponent never overflows.
  - y = {s, e[7:0], frac}.
  - nx = G | St.
  - z forces y = 0x00000000 and nx = 0 (never 0x80000000).
- Boundaries:
  - |x| < 2^24 is always exact (nx=0).
  - A ties-to-even carry at 2^32-1 unsigned yields 2^32.
  - Back-to-back operands with out_ready toggling must lose and duplicate nothing.
  - An operand accepted in the same cycle out_ready drops is held, not lost.
  - in_valid=0 cycles insert bubbles that propagate as out_valid=0.

Test Plan:
- Reset mid-flight: accept 3 operands, pulse rstn low asynchronously between edges → out_valid=0 and y=0 immediately. After release, the old operands never appear and in_ready=1.
- Basic signed (uns=0, out_ready=1): 0x00000001→0x3F800000; 0xFFFFFFFF→0xBF800000; 0x00000000→0x00000000; 0x80000000→0xCF000000; 0x7FFFFFFF→0x4F000000 with nx=1. Each appears 3 cycles after acceptance.
- Rounding (signed): 16777217→0x4B800000 (tie to even, nx=1); 16777219→0x4B800002 (tie up, nx=1); 16777216→0x4B800000 (nx=0); -16777217→0xCB800000.
- Unsigned: 0xFFFFFFFF→0x4F800000 (mantissa carry into exponent, nx=1); 0x80000000→0x4F000000 (nx=0); 0x00000003→0x40400000.
- Backpressure: stream 10 random operands every cycle with out_ready randomly low → in_ready = ~out_valid|out_ready every cycle, y stable while stalled, outputs in order, and all 10 match the reference model.
- Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 → out_valid pattern 1,0,1,0 starting 3 cycles later. With ZERO_ON_IDLE=1, y=0 in the gap cycles.
